// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU op encoding and default sizing for param_exec_pipe
package pipe_pkg;
   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_SLT   = 3'd5,
      OP_SLTU  = 3'd6,
      OP_PASSB = 3'd7
   } alu_op_e;
   localparam int DEF_XLEN   = 32;
   localparam int DEF_NREG   = 32;
   localparam int DEF_STAGES = 3;
endpackage

// File: rtl/pipe_alu.sv
// pipe_alu: combinational XLEN-wide ALU
//   op  : alu_op_e operation select
//   a,b : operands
//   y   : result (wraps modulo 2^XLEN; compares give zero-extended 0/1)
module pipe_alu
   import pipe_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:   y = a + b;
         OP_SUB:   y = a - b;
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
         OP_PASSB: y = b;
         default:  y = '0;
      endcase
   end
endmodule

// File: rtl/param_exec_pipe.sv
// param_exec_pipe: in-order execute->writeback pipeline with forwarding and load interlock
//   clk, n_rst (async active-low)
//   issue_*  : instruction offer; issue_ready accepts it this cycle
//   flush    : kills stages 1..STAGES-1, blocks issue this cycle
//   mem_req/mem_addr : load request from stage 1; mem_rdata returns one cycle later
//   wb_valid/wb_rd/wb_data : writeback from the last stage
//   tohost   : tohost register (only real when TOHOST_CSR_EN is defined, else 0)
module param_exec_pipe
   import pipe_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREG   = DEF_NREG,
   parameter int STAGES = DEF_STAGES,
   localparam int RW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [RW-1:0]   issue_rs1,
   input  logic [RW-1:0]   issue_rs2,
   input  logic [RW-1:0]   issue_rd,
   input  logic [2:0]      issue_op,
   input  logic [XLEN-1:0] issue_imm,
   input  logic            issue_use_imm,
   input  logic            issue_load,
   input  logic            issue_csr,
   input  logic            flush,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [RW-1:0]   wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] tohost
);
   logic            v   [1:STAGES];
   logic [RW-1:0]   rd  [1:STAGES];
   logic            ld  [1:STAGES];
   logic [XLEN-1:0] res [2:STAGES];
   logic [XLEN-1:0] r_eff [1:STAGES];
   logic [XLEN-1:0] rf  [NREG];
   logic [XLEN-1:0] a1, b1, alu_y, fwd_a, fwd_b;
   alu_op_e         op1;
   logic            stall, accept;

   pipe_alu #(.XLEN(XLEN)) u_alu (.op(op1), .a(a1), .b(b1), .y(alu_y));

   // A load's data only exists in stage 2 (mem_rdata arrives the cycle after the request)
   always_comb begin
      r_eff[1] = alu_y;
      for (int k = 2; k <= STAGES; k++)
         r_eff[k] = (k == 2 && ld[k]) ? mem_rdata : res[k];
   end

   // Oldest first so younger matches overwrite; stage 1 loads have no data yet
   always_comb begin
      fwd_a = rf[issue_rs1];
      fwd_b = rf[issue_rs2];
      for (int k = STAGES; k >= 2; k--) begin
         if (v[k] && rd[k] != '0 && rd[k] == issue_rs1) fwd_a = r_eff[k];
         if (v[k] && rd[k] != '0 && rd[k] == issue_rs2) fwd_b = r_eff[k];
      end
      if (v[1] && !ld[1] && rd[1] != '0 && rd[1] == issue_rs1) fwd_a = alu_y;
      if (v[1] && !ld[1] && rd[1] != '0 && rd[1] == issue_rs2) fwd_b = alu_y;
   end

   assign stall = v[1] & ld[1] & (rd[1] != '0) &
                  ((rd[1] == issue_rs1) | (~issue_use_imm & (rd[1] == issue_rs2)));
   assign issue_ready = ~flush & ~stall;
   assign accept      = issue_valid & issue_ready;
   assign mem_req     = v[1] & ld[1];
   assign mem_addr    = alu_y;
   assign wb_valid    = v[STAGES];
   assign wb_rd       = rd[STAGES];
   assign wb_data     = r_eff[STAGES];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 1; k <= STAGES; k++) v[k] <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         v[1] <= accept;
         for (int k = 2; k <= STAGES; k++) v[k] <= v[k-1] & ~flush;
         if (v[STAGES] && rd[STAGES] != '0) rf[rd[STAGES]] <= r_eff[STAGES];
      end
   end

   // Payload needs no reset: every use is qualified by its valid bit
   always_ff @(posedge clk) begin
      a1     <= fwd_a;
      b1     <= (issue_use_imm | issue_load) ? issue_imm : fwd_b;
      op1    <= issue_load ? OP_ADD : alu_op_e'(issue_op);
      rd[1]  <= issue_rd;
      ld[1]  <= issue_load;
      res[2] <= alu_y;
      for (int k = 2; k <= STAGES; k++) begin
         rd[k] <= rd[k-1];
         ld[k] <= ld[k-1];
      end
      for (int k = 3; k <= STAGES; k++) res[k] <= r_eff[k-1];
   end

`ifdef TOHOST_CSR_EN
   logic            csr1;
   logic [XLEN-1:0] tohost_q;
   always_ff @(posedge clk) csr1 <= issue_csr;
   // a1 holds the forwarded rs1 value of the stage 1 entry
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) tohost_q <= '0;
      else if (v[1] && csr1 && !flush) tohost_q <= a1;
   end
   assign tohost = tohost_q;
`else
   logic unused_csr;
   assign unused_csr = issue_csr;
   assign tohost     = '0;
`endif
endmodule

// File: doc/param_exec_pipe.md
PARAM_EXEC_PIPE -- requirements
Module: param_exec_pipe

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2); RW = log2(NREG).
REQ-003 SHALL have parameter STAGES, default 3, stages from execute (stage 1) to writeback (stage STAGES); legal range 2..8.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  instruction accepted this cycle
- issue_rs1, issue_rs2, issue_rd  in  RW  register indices
- issue_op  in  3  ALU op: ADD, SUB, AND, OR, XOR, SLT, SLTU, PASSB
- issue_imm  in  XLEN  immediate
- issue_use_imm  in  1  B operand is issue_imm instead of rs2
- issue_load  in  1  load: address = rs1+imm; result comes from mem_rdata
- issue_csr  in  1  tohost write of rs1 value
- flush  in  1  kill in-flight non-writeback work
- mem_req  out  1  load request
- mem_addr  out  XLEN  load address
- mem_rdata  in  XLEN  load data, valid the cycle after mem_req
- wb_valid  out  1  writeback this cycle
- wb_rd  out  RW  writeback index
- wb_data  out  XLEN  writeback value
- tohost  out  XLEN  tohost register

Function
REQ-005 issue_ready SHALL be 0 when stage 1 holds a valid load whose rd is nonzero and equals the issuing rs1 or the issuing rs2 (rs2 checked only if issue_use_imm=0); otherwise 1. A stall SHALL insert a bubble into stage 1.
REQ-006 Accept (issue_valid & issue_ready) SHALL capture operands, op and control into stage 1 at the next edge; stage k SHALL advance to stage k+1 every cycle (no back-pressure past issue).
REQ-007 Operands SHALL be resolved at issue with priority youngest-first: stage 1 ALU result, then stages 2..STAGES, then the register file. Only valid entries with matching nonzero rd SHALL forward. Load entries SHALL forward only from stage 2 onward.
REQ-008 Index 0 SHALL always read 0 and SHALL never be written.
REQ-009 Stage 1 SHALL compute the ALU result combinationally. SLT/SLTU SHALL be signed/unsigned compares with a zero-extended 1-bit result. Arithmetic SHALL wrap modulo 2^XLEN.
REQ-010 For a valid load in stage 1, the block SHALL drive mem_req=1 and mem_addr=ALU result. It SHALL capture mem_rdata into the stage 2 result.
REQ-011 A valid entry in stage STAGES SHALL assert wb_valid, wb_rd and wb_data combinationally and write the register file at that edge. A same-cycle issue read of that rd SHALL bypass via REQ-007.
REQ-012 Issue-to-writeback latency SHALL be exactly STAGES cycles after acceptance.
REQ-013 flush SHALL clear valid in stages 1..STAGES-1 and block acceptance that cycle (issue_ready=0). The stage STAGES writeback that cycle SHALL still complete.
REQ-014 Flush and a load-stall in the same cycle: flush SHALL win.

Reset
REQ-015 n_rst low SHALL clear all stage valids, all register-file entries and tohost to 0. It SHALL force wb_valid=0 and mem_req=0; issue_ready SHALL then be 1.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight entries with no writeback.

Configuration
REQ-017 With TOHOST_CSR_EN defined: an accepted issue_csr SHALL load tohost with the forwarded rs1 value at the end of that entry's stage 1 cycle, unless it is flushed.
REQ-018 Without TOHOST_CSR_EN: tohost SHALL be constant 0, issue_csr SHALL be ignored, and no tohost flop SHALL exist.

Structure
REQ-019 The ALU op encoding and default XLEN/NREG/STAGES constants SHALL reside in shared package pipe_pkg.
REQ-020 The ALU SHALL be sub-module pipe_alu (combinational, XLEN-parameterised). Stage registers, forwarding and interlock SHALL stay in param_exec_pipe.

Verification
REQ-021 ADD x1=x0+imm 5, then ADD x2=x1+imm 3 back-to-back -> no stall; wb x1=5 at cycle 3, wb x2=8 at cycle 4 (STAGES=3).
REQ-022 Load x3 (rdata 0xDEADBEEF), then ADD x4=x3+x0 next cycle -> issue_ready=0 for one cycle; wb x4=0xDEADBEEF.
REQ-023 ADD x0=imm 7, then read x0 -> operand 0; wb_valid=1 with no register change.
REQ-024 flush raised with three entries in flight -> only the stage-STAGES entry writes back; the next issue is accepted one cycle later.
REQ-025 SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0; SUB 0-1 -> 0xFFFFFFFF.
REQ-026 TOHOST_CSR_EN with x5=0x1, csr issue rs1=x5 -> tohost=0x1 two cycles later; repeat with the macro undefined -> tohost stays 0.
